// File: rtl/rope_solver.sv
// Time-multiplexed Verlet rope: one shared datapath steps every node per frame
// (latch, integrate, ITER relax passes, publish to a double-buffered snapshot).
module rope_solver #(
  parameter int NODES   = 20,
  parameter int WORD    = 32,
  parameter int FRAC    = 12,
  parameter int ITER    = 4,
  parameter int SEG     = 8,
  parameter int GRAVITY = 2048,
  parameter int INIT_X  = 320,
  parameter int INIT_Y  = 40
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  start,
  input  logic                  pin_tail,
  input  logic [9:0]            in_mouse_x,
  input  logic [9:0]            in_mouse_y,
  input  logic [9:0]            in_tail_x,
  input  logic [9:0]            in_tail_y,
  output logic                  busy,
  output logic                  done,
  output logic [NODES*10-1:0]   nodes_x,
  output logic [NODES*10-1:0]   nodes_y
);

  localparam int IW  = $clog2(NODES);
  localparam int ITW = $clog2(ITER + 1);
  localparam logic [IW-1:0] LAST = IW'(NODES - 1);
  localparam logic signed [WORD-1:0] SEGF = WORD'(SEG) <<< FRAC;
  localparam logic signed [WORD-1:0] MAXV = (WORD'(1024) <<< FRAC) - WORD'(1);
  localparam logic signed [WORD-1:0] GRAV = WORD'(GRAVITY);

  typedef enum logic [2:0] {
    IDLE, LATCH, INTEGRATE, RELAX_FWD, RELAX_BWD, PUBLISH
  } state_t;

  function automatic logic signed [WORD-1:0] sat(input logic signed [WORD-1:0] v);
    if (v < 0) return '0;
    else if (v > MAXV) return MAXV;
    else return v;
  endfunction

  function automatic logic signed [WORD-1:0] to_fix(input logic [9:0] p);
    return $signed({{(WORD-10){1'b0}}, p} << FRAC);
  endfunction

  function automatic logic signed [WORD-1:0] relax(input logic signed [WORD-1:0] cur,
                                                   input logic signed [WORD-1:0] rf);
    logic signed [WORD-1:0] d;
    d = cur - rf;
    if (d > SEGF) return sat(rf + SEGF);
    else if (d < -SEGF) return sat(rf - SEGF);
    else return cur;
  endfunction

  state_t                 state;
  logic [IW-1:0]          idx;
  logic [IW-1:0]          ridx;
  logic [ITW-1:0]         iter;
  logic                   pin_q;
  logic [9:0]             mouse_x_q, mouse_y_q, tail_x_q, tail_y_q;
  logic signed [WORD-1:0] pos_x  [NODES];
  logic signed [WORD-1:0] pos_y  [NODES];
  logic signed [WORD-1:0] prev_x [NODES];
  logic signed [WORD-1:0] prev_y [NODES];
  logic [NODES*10-1:0]    snap_x, snap_y;
  logic signed [WORD-1:0] cur_x, cur_y, ref_x, ref_y;
  logic signed [WORD-1:0] int_x, int_y, rlx_x, rlx_y;
  logic                   last_pass, hold_tail;

  always_comb begin
    ridx      = (state == RELAX_BWD) ? idx + IW'(1)
              : ((idx == '0) ? '0 : idx - IW'(1));
    cur_x     = pos_x[idx];
    cur_y     = pos_y[idx];
    ref_x     = pos_x[ridx];
    ref_y     = pos_y[ridx];
    int_x     = sat(cur_x + (cur_x - prev_x[idx]));
    int_y     = sat(cur_y + (cur_y - prev_y[idx]) + GRAV);
    rlx_x     = relax(cur_x, ref_x);
    rlx_y     = relax(cur_y, ref_y);
    last_pass = (iter == ITW'(ITER - 1));
    hold_tail = pin_q && (idx == LAST);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= IDLE;
      busy      <= 1'b0;
      done      <= 1'b0;
      idx       <= '0;
      iter      <= '0;
      pin_q     <= 1'b0;
      mouse_x_q <= '0;
      mouse_y_q <= '0;
      tail_x_q  <= '0;
      tail_y_q  <= '0;
      for (int k = 0; k < NODES; k++) begin
        pos_x[k]           <= to_fix(10'(INIT_X));
        pos_y[k]           <= to_fix(10'(INIT_Y + k * SEG));
        prev_x[k]          <= to_fix(10'(INIT_X));
        prev_y[k]          <= to_fix(10'(INIT_Y + k * SEG));
        snap_x[k*10 +: 10] <= 10'(INIT_X);
        snap_y[k*10 +: 10] <= 10'(INIT_Y + k * SEG);
      end
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          // Inputs are captured on the accepting edge so later changes cannot leak in.
          if (start) begin
            mouse_x_q <= in_mouse_x;
            mouse_y_q <= in_mouse_y;
            tail_x_q  <= in_tail_x;
            tail_y_q  <= in_tail_y;
            pin_q     <= pin_tail;
            busy      <= 1'b1;
            state     <= LATCH;
          end
        end
        LATCH: begin
          pos_x[0]  <= to_fix(mouse_x_q);
          pos_y[0]  <= to_fix(mouse_y_q);
          prev_x[0] <= to_fix(mouse_x_q);
          prev_y[0] <= to_fix(mouse_y_q);
          idx       <= IW'(1);
          state     <= INTEGRATE;
        end
        INTEGRATE: begin
          if (hold_tail) begin
            pos_x[idx]  <= to_fix(tail_x_q);
            pos_y[idx]  <= to_fix(tail_y_q);
            prev_x[idx] <= to_fix(tail_x_q);
            prev_y[idx] <= to_fix(tail_y_q);
          end else begin
            pos_x[idx]  <= int_x;
            pos_y[idx]  <= int_y;
            prev_x[idx] <= cur_x;
            prev_y[idx] <= cur_y;
          end
          if (idx == LAST) begin
            idx   <= IW'(1);
            iter  <= '0;
            state <= RELAX_FWD;
          end else begin
            idx <= idx + IW'(1);
          end
        end
        RELAX_FWD: begin
          if (!hold_tail) begin
            pos_x[idx] <= rlx_x;
            pos_y[idx] <= rlx_y;
          end
          if (idx != LAST) begin
            idx <= idx + IW'(1);
          end else if (pin_q) begin
            idx   <= LAST - IW'(1);
            state <= RELAX_BWD;
          end else if (last_pass) begin
            busy  <= 1'b0;
            done  <= 1'b1;
            state <= PUBLISH;
          end else begin
            iter <= iter + ITW'(1);
            idx  <= IW'(1);
          end
        end
        RELAX_BWD: begin
          pos_x[idx] <= rlx_x;
          pos_y[idx] <= rlx_y;
          if (idx != IW'(1)) begin
            idx <= idx - IW'(1);
          end else if (last_pass) begin
            busy  <= 1'b0;
            done  <= 1'b1;
            state <= PUBLISH;
          end else begin
            iter  <= iter + ITW'(1);
            idx   <= IW'(1);
            state <= RELAX_FWD;
          end
        end
        PUBLISH: begin
          for (int k = 0; k < NODES; k++) begin
            snap_x[k*10 +: 10] <= pos_x[k][FRAC+9:FRAC];
            snap_y[k*10 +: 10] <= pos_y[k][FRAC+9:FRAC];
          end
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign nodes_x = snap_x;
  assign nodes_y = snap_y;

endmodule

// File: tb/tb_rope_solver.sv
// Scoreboarded bench for rope_solver: a plain-arithmetic rope model predicts each
// published snapshot and its done cycle; a monitor checks them as done pulses.
module tb_rope_solver;

  localparam int N  = 4;
  localparam int IT = 1;
  localparam int SG = 8;
  localparam int GR = 2048;
  localparam int FR = 12;
  localparam int IX = 320;
  localparam int IY = 40;
  localparam longint SEGF = longint'(SG) << FR;
  localparam longint MAXV = (longint'(1024) << FR) - 1;

  logic            clk = 1'b0;
  logic            reset = 1'b1;
  logic            start = 1'b0;
  logic            pin_tail = 1'b0;
  logic [9:0]      in_mouse_x = '0, in_mouse_y = '0, in_tail_x = '0, in_tail_y = '0;
  logic            busy, done;
  logic [N*10-1:0] nodes_x, nodes_y;

  rope_solver #(
    .NODES(N), .WORD(32), .FRAC(FR), .ITER(IT), .SEG(SG),
    .GRAVITY(GR), .INIT_X(IX), .INIT_Y(IY)
  ) dut (
    .clk(clk), .reset(reset), .start(start), .pin_tail(pin_tail),
    .in_mouse_x(in_mouse_x), .in_mouse_y(in_mouse_y),
    .in_tail_x(in_tail_x), .in_tail_y(in_tail_y),
    .busy(busy), .done(done), .nodes_x(nodes_x), .nodes_y(nodes_y)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_vec = 0;
  int n_mis = 0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_mis++;
      $display("FAIL %s at cycle %0d: got %0h, expected %0h", nm, cyc, act, exp);
    end
  endtask

  // Reference rope, in fixed point, stepped one whole frame at a time.
  longint m_px[N], m_py[N], m_qx[N], m_qy[N];

  function automatic longint clampv(input longint v);
    if (v < 0) return 0;
    if (v > MAXV) return MAXV;
    return v;
  endfunction

  function automatic longint relax1(input longint cur, input longint rf);
    longint d;
    d = cur - rf;
    if (d > SEGF) return clampv(rf + SEGF);
    if (d < -SEGF) return clampv(rf - SEGF);
    return cur;
  endfunction

  task automatic model_reset();
    for (int i = 0; i < N; i++) begin
      m_px[i] = longint'(IX) << FR;
      m_py[i] = longint'(IY + i * SG) << FR;
      m_qx[i] = m_px[i];
      m_qy[i] = m_py[i];
    end
  endtask

  task automatic model_frame(input int mx, input int my, input bit pin, input int tx, input int ty);
    longint nx, ny;
    m_px[0] = longint'(mx) << FR;  m_qx[0] = m_px[0];
    m_py[0] = longint'(my) << FR;  m_qy[0] = m_py[0];
    for (int i = 1; i < N; i++) begin
      if (pin && i == N - 1) begin
        m_px[i] = longint'(tx) << FR;  m_qx[i] = m_px[i];
        m_py[i] = longint'(ty) << FR;  m_qy[i] = m_py[i];
      end else begin
        nx = 2 * m_px[i] - m_qx[i];
        ny = 2 * m_py[i] - m_qy[i] + GR;
        m_qx[i] = m_px[i];
        m_qy[i] = m_py[i];
        m_px[i] = clampv(nx);
        m_py[i] = clampv(ny);
      end
    end
    for (int it = 0; it < IT; it++) begin
      for (int i = 1; i < N; i++)
        if (!(pin && i == N - 1)) begin
          m_px[i] = relax1(m_px[i], m_px[i-1]);
          m_py[i] = relax1(m_py[i], m_py[i-1]);
        end
      if (pin)
        for (int i = N - 2; i >= 1; i--) begin
          m_px[i] = relax1(m_px[i], m_px[i+1]);
          m_py[i] = relax1(m_py[i], m_py[i+1]);
        end
    end
  endtask

  function automatic logic [63:0] pack(input bit is_y);
    logic [63:0] r;
    r = '0;
    for (int i = 0; i < N; i++)
      r[i*10 +: 10] = 10'((is_y ? m_py[i] : m_px[i]) >> FR);
    return r;
  endfunction

  function automatic int frame_len(input bit pin);
    return 1 + (N - 1) + IT * ((N - 1) + (pin ? N - 2 : 0));
  endfunction

  typedef struct {
    logic [63:0] x;
    logic [63:0] y;
    int          when;
  } exp_t;
  exp_t sb[$];

  task automatic push_exp(input int mx, input int my, input bit pin, input int tx, input int ty,
                          input int t);
    exp_t e;
    model_frame(mx, my, pin, tx, ty);
    e.x = pack(1'b0);
    e.y = pack(1'b1);
    e.when = t + frame_len(pin);
    sb.push_back(e);
  endtask

  // Monitor: on done, pop the prediction and check timing; one cycle later the snapshot.
  bit          pend = 0;
  logic [63:0] pend_x, pend_y;
  always @(negedge clk) begin
    exp_t e;
    if (pend) begin
      chk("snapshot_x", 64'(nodes_x), pend_x);
      chk("snapshot_y", 64'(nodes_y), pend_y);
      pend = 0;
    end
    if (done) begin
      if (sb.size() == 0) begin
        n_vec++;
        n_mis++;
        $display("FAIL unexpected_done at cycle %0d: got done=1, expected done=0", cyc);
      end else begin
        e = sb.pop_front();
        chk("done_cycle", 64'(cyc), 64'(e.when));
        chk("busy_at_done", 64'(busy), 64'(0));
        pend_x = e.x;
        pend_y = e.y;
        pend = 1;
      end
    end
  end

  task automatic set_inputs(input int mx, input int my, input bit pin, input int tx, input int ty);
    in_mouse_x = 10'(mx);
    in_mouse_y = 10'(my);
    pin_tail   = pin;
    in_tail_x  = 10'(tx);
    in_tail_y  = 10'(ty);
  endtask

  // One frame; with noise, inputs and start toggle randomly while the frame runs.
  task automatic frame(input int mx, input int my, input bit pin, input int tx, input int ty,
                       input bit noise);
    int t, l;
    @(negedge clk);
    set_inputs(mx, my, pin, tx, ty);
    start = 1'b1;
    @(negedge clk);
    t = cyc;
    start = 1'b0;
    l = frame_len(pin);
    push_exp(mx, my, pin, tx, ty, t);
    chk("busy_after_start", 64'(busy), 64'(1));
    while (cyc < t + l + 1) begin
      if (noise) begin
        set_inputs($urandom_range(0, 1023), $urandom_range(0, 1023), 1'($urandom),
                   $urandom_range(0, 1023), $urandom_range(0, 1023));
        start = 1'($urandom);
      end
      @(negedge clk);
    end
    start = 1'b0;
    @(negedge clk);
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    model_reset();
  endtask

  task automatic check_reset_state(input string tag);
    chk({tag, "_busy"}, 64'(busy), 64'(0));
    chk({tag, "_done"}, 64'(done), 64'(0));
    chk({tag, "_x"}, 64'(nodes_x), pack(1'b0));
    chk({tag, "_y"}, 64'(nodes_y), pack(1'b1));
  endtask

  initial begin
    int t, t2, l;
    model_reset();
    repeat (3) @(negedge clk);
    reset = 1'b0;
    check_reset_state("reset");

    // Resting rope: gravity half-pixel sag relaxed back out.
    frame(320, 40, 0, 0, 0, 0);
    chk("plan_rest_x", 64'(nodes_x), 64'({10'd320, 10'd320, 10'd320, 10'd320}));
    chk("plan_rest_y", 64'(nodes_y), 64'({10'd64, 10'd56, 10'd48, 10'd40}));

    do_reset();
    frame(400, 40, 0, 0, 0, 0);
    chk("plan_drag_x", 64'(nodes_x), 64'({10'd376, 10'd384, 10'd392, 10'd400}));
    chk("plan_drag_y", 64'(nodes_y), 64'({10'd64, 10'd56, 10'd48, 10'd40}));

    do_reset();
    frame(320, 40, 1, 320, 64, 0);
    chk("plan_pin_y", 64'(nodes_y), 64'({10'd64, 10'd56, 10'd48, 10'd40}));

    // Mouse near the bottom edge; repeated frames let gravity push into the clamp.
    do_reset();
    repeat (8) frame(320, 1020, 0, 0, 0, 0);
    repeat (6) frame(0, 0, 0, 0, 0, 0);
    repeat (4) frame(1023, 1023, 1, 1023, 1023, 0);

    // Inputs and start wiggling mid-frame must not affect the result.
    frame(500, 300, 0, 0, 0, 1);
    frame(100, 700, 1, 200, 900, 1);

    // Start held high: the second frame launches from the first IDLE cycle after PUBLISH.
    @(negedge clk);
    set_inputs(250, 200, 0, 0, 0);
    start = 1'b1;
    @(negedge clk);
    t = cyc;
    l = frame_len(1'b0);
    push_exp(250, 200, 0, 0, 0, t);
    while (cyc < t + l + 1) @(negedge clk);
    @(negedge clk);
    t2 = cyc;
    start = 1'b0;
    push_exp(250, 200, 0, 0, 0, t2);
    while (cyc < t2 + l + 2) @(negedge clk);

    // Reset in the fourth cycle of a frame aborts it without a done pulse.
    frame(700, 100, 0, 0, 0, 0);
    @(negedge clk);
    set_inputs(50, 900, 0, 0, 0);
    start = 1'b1;
    @(negedge clk);
    t = cyc;
    start = 1'b0;
    while (cyc < t + 3) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    model_reset();
    check_reset_state("abort");
    repeat (12) @(negedge clk);

    for (int k = 0; k < 25; k++)
      frame($urandom_range(0, 1023), $urandom_range(0, 1023), 1'($urandom),
            $urandom_range(0, 1023), $urandom_range(0, 1023), 1'($urandom));

    repeat (15) @(negedge clk);
    chk("scoreboard_drained", 64'(sb.size()), 64'(0));
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_mis);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation exceeded its time limit");
    $fatal(1, "watchdog");
  end

endmodule
